// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
//
// Per-pixel layer compositor. On pix_start it latches the blob requests,
// resolves one owner blob per layer (lowest requesting index wins), then reads
// sprite RAM from the topmost requested layer downwards. Layers nobody
// requested are skipped. The scan stops at the first pixel that differs from
// transparent_key. If every requested layer is transparent, or nothing was
// requested, the background colour is output instead.
//
// Optional feature (macro LAYER_COMPOSITOR_COLLISION_EN):
//   When the macro is defined, collision / collision_mask report blobs that
//   share a layer with another requesting blob.
//   When it is undefined, both outputs are tied low and no collision logic is
//   built.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   background        colour used when no opaque pixel is found
//   transparent_key   pixel value treated as transparent
//   layer[b]          layer of blob b (layer NR_OF_LAYERS-1 is topmost)
//   address[b]        sprite RAM address of blob b for this pixel
//   request[b]        blob b requests this pixel
//   pix_start         slot strobe, sampled only while ready=1
//   ready             idle, will accept pix_start
//   rd_en, rd_add     sprite RAM read port (data returns one cycle later)
//   rd_data           sprite RAM read data
//   pixel_out         composited pixel, held between strobes
//   pixel_valid       one-cycle strobe, pixel_out valid
//   collision         same-layer conflict in this pixel, valid with pixel_valid
//   collision_mask    blobs involved in a same-layer conflict
// -----------------------------------------------------------------------------
module layer_compositor #(
  parameter  int ADD_WIDTH    = 16,
  parameter  int PIXEL_WIDTH  = 12,
  parameter  int NR_OF_BLOBS  = 8,
  parameter  int NR_OF_LAYERS = 4,
  localparam int LAYER_W      = $clog2(NR_OF_LAYERS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [PIXEL_WIDTH-1:0]                background,
  input  logic [PIXEL_WIDTH-1:0]                transparent_key,
  input  logic [NR_OF_BLOBS-1:0][LAYER_W-1:0]   layer,
  input  logic [NR_OF_BLOBS-1:0][ADD_WIDTH-1:0] address,
  input  logic [NR_OF_BLOBS-1:0]                request,
  input  logic                                  pix_start,
  output logic                                  ready,
  output logic                                  rd_en,
  output logic [ADD_WIDTH-1:0]                  rd_add,
  input  logic [PIXEL_WIDTH-1:0]                rd_data,
  output logic [PIXEL_WIDTH-1:0]                pixel_out,
  output logic                                  pixel_valid,
  output logic                                  collision,
  output logic [NR_OF_BLOBS-1:0]                collision_mask
);

  typedef enum logic [2:0] {IDLE, LOOKUP, READ, CHECK, DONE} state_t;

  state_t                                  state_q;
  logic [NR_OF_BLOBS-1:0]                  req_q;
  logic [NR_OF_BLOBS-1:0][LAYER_W-1:0]     layer_q;
  logic [NR_OF_BLOBS-1:0][ADD_WIDTH-1:0]   addr_q;
  logic [NR_OF_LAYERS-1:0]                 layer_req_q;
  logic [NR_OF_LAYERS-1:0][ADD_WIDTH-1:0]  owner_add_q;
  logic [LAYER_W-1:0]                      cur_q;

  logic [NR_OF_LAYERS-1:0]                 layer_req_d;
  logic [NR_OF_LAYERS-1:0][ADD_WIDTH-1:0]  owner_add_d;
  logic [LAYER_W-1:0]                      top_d;
  logic [LAYER_W-1:0]                      lower_d;
  logic                                    has_lower_d;

  // Owner resolution works on the latched copy so input changes after the
  // latch cycle cannot disturb the slot in progress.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    layer_req_d = '0;
    owner_add_d = '0;
    // Walk blobs high to low so the lowest requesting index is written last.
    for (int i = NR_OF_BLOBS - 1; i >= 0; i--) begin
      if (req_q[i]) begin
        layer_req_d[layer_q[i]] = 1'b1;
        owner_add_d[layer_q[i]] = addr_q[i];
      end
    end

    top_d = '0;
    for (int l = 0; l < NR_OF_LAYERS; l++) begin
      if (layer_req_d[l]) top_d = LAYER_W'(l);
    end

    // Highest requested layer strictly below the one just read.
    lower_d     = '0;
    has_lower_d = 1'b0;
    for (int l = 0; l < NR_OF_LAYERS; l++) begin
      if (layer_req_q[l] && (LAYER_W'(l) < cur_q)) begin
        lower_d     = LAYER_W'(l);
        has_lower_d = 1'b1;
      end
    end
  end

  // Slot datapath. Its contents are only meaningful after a latch, so it
  // carries no reset.
  // NOTE: pure data registers are left unreset; the FSM guarantees they are
  // written before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && pix_start) begin
      req_q   <= request;
      layer_q <= layer;
      addr_q  <= address;
    end
    if (state_q == LOOKUP) begin
      layer_req_q <= layer_req_d;
      owner_add_q <= owner_add_d;
      cur_q       <= top_d;
    end else if (state_q == CHECK && has_lower_d) begin
      cur_q <= lower_d;
    end
  end

  // Control FSM with registered outputs. Each output is set on the transition
  // into the state where it must be visible.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ready       <= 1'b1;
      rd_en       <= 1'b0;
      rd_add      <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else begin
      rd_en       <= 1'b0;
      pixel_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pix_start) begin
            ready   <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (|layer_req_d) begin
            rd_en   <= 1'b1;
            rd_add  <= owner_add_d[top_d];
            state_q <= READ;
          end else begin
            pixel_out   <= background;
            pixel_valid <= 1'b1;
            state_q     <= DONE;
          end
        end
        READ: state_q <= CHECK;
        CHECK: begin
          if (rd_data != transparent_key) begin
            pixel_out   <= rd_data;
            pixel_valid <= 1'b1;
            state_q     <= DONE;
          end else if (has_lower_d) begin
            rd_en   <= 1'b1;
            rd_add  <= owner_add_q[lower_d];
            state_q <= READ;
          end else begin
            pixel_out   <= background;
            pixel_valid <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          ready   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LAYER_COMPOSITOR_COLLISION_EN
  logic [NR_OF_LAYERS-1:0] seen_d;
  logic [NR_OF_LAYERS-1:0] multi_d;
  logic [NR_OF_BLOBS-1:0]  coll_mask_d;
  logic [NR_OF_BLOBS-1:0]  coll_mask_q;
  logic                    go_done;

  // A layer is contested once a second requester lands on it; every
  // requester on a contested layer, owner included, is flagged.
  always_comb begin
    seen_d  = '0;
    multi_d = '0;
    for (int i = 0; i < NR_OF_BLOBS; i++) begin
      if (req_q[i]) begin
        if (seen_d[layer_q[i]]) multi_d[layer_q[i]] = 1'b1;
        seen_d[layer_q[i]] = 1'b1;
      end
    end
    coll_mask_d = '0;
    for (int i = 0; i < NR_OF_BLOBS; i++) begin
      coll_mask_d[i] = req_q[i] & multi_d[layer_q[i]];
    end
  end

  // Same conditions under which the FSM enters DONE.
  assign go_done = (state_q == LOOKUP && !(|layer_req_d)) ||
                   (state_q == CHECK && (rd_data != transparent_key || !has_lower_d));

  always_ff @(posedge clk) begin
    if (reset) begin
      coll_mask_q    <= '0;
      collision      <= 1'b0;
      collision_mask <= '0;
    end else begin
      if (state_q == LOOKUP) coll_mask_q <= coll_mask_d;
      if (go_done) begin
        // An empty slot finishes straight from LOOKUP, before coll_mask_q is loaded.
        collision_mask <= (state_q == LOOKUP) ? coll_mask_d : coll_mask_q;
        collision      <= (state_q == LOOKUP) ? |coll_mask_d : |coll_mask_q;
      end
    end
  end
`else
  assign collision      = 1'b0;
  assign collision_mask = '0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
//
// Scoreboard bench for layer_compositor with default parameters. A behavioural
// model predicts pixel, collision info and latency when a slot is launched.
// The prediction is queued, and a monitor pops it on each pixel_valid. The
// sprite RAM is a registered-read array that also logs read addresses.
// -----------------------------------------------------------------------------
module tb_layer_compositor;

  localparam int NB = 8;
  localparam int NL = 4;

  typedef struct {
    logic [11:0] pixel;
    logic        coll;
    logic [7:0]  mask;
    int          cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [11:0]          bg;
  logic [11:0]          key;
  logic [NB-1:0][1:0]   lay;
  logic [NB-1:0][15:0]  addr;
  logic [NB-1:0]        req;
  logic                 pix_start;
  logic                 ready;
  logic                 rd_en;
  logic [15:0]          rd_add;
  logic [11:0]          rd_data = '0;
  logic [11:0]          pixel_out;
  logic                 pixel_valid;
  logic                 collision;
  logic [NB-1:0]        collision_mask;

  logic [11:0]          mem [0:65535];
  logic [15:0]          rd_log [$];
  exp_t                 sb [$];
  int                   cyc = 0;
  int                   n_checks = 0;
  int                   n_fail = 0;

  layer_compositor dut (
    .clk            (clk),
    .reset          (reset),
    .background     (bg),
    .transparent_key(key),
    .layer          (lay),
    .address        (addr),
    .request        (req),
    .pix_start      (pix_start),
    .ready          (ready),
    .rd_en          (rd_en),
    .rd_add         (rd_add),
    .rd_data        (rd_data),
    .pixel_out      (pixel_out),
    .pixel_valid    (pixel_valid),
    .collision      (collision),
    .collision_mask (collision_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sprite RAM: data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_add];
      rd_log.push_back(rd_add);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: walk layers top-down, owner = lowest requesting blob.
  function automatic void predict(output exp_t e, output int k);
    logic found;
    int   owner;
    int   cnt;
    e.pixel = bg;
    e.coll  = 1'b0;
    e.mask  = '0;
    e.cyc   = 0;
    k       = 0;
    found   = 1'b0;
    for (int l = NL - 1; l >= 0; l--) begin
      owner = -1;
      for (int i = 0; i < NB; i++)
        if (req[i] && 32'(lay[i]) == l && owner < 0) owner = i;
      if (owner >= 0 && !found) begin
        k++;
        if (mem[addr[owner]] != key) begin
          e.pixel = mem[addr[owner]];
          found   = 1'b1;
        end
      end
    end
`ifdef LAYER_COMPOSITOR_COLLISION_EN
    for (int i = 0; i < NB; i++) begin
      cnt = 0;
      for (int j = 0; j < NB; j++)
        if (j != i && req[j] && lay[j] == lay[i]) cnt++;
      if (req[i] && cnt > 0) e.mask[i] = 1'b1;
    end
    e.coll = |e.mask;
`endif
  endfunction

  // Monitor: every pixel_valid must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && pixel_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(pixel_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pixel", 32'(pixel_out), 32'(e.pixel));
        check("collision", 32'(collision), 32'(e.coll));
        check("coll_mask", 32'(collision_mask), 32'(e.mask));
        check("latency_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic clear_inputs();
    req  = '0;
    lay  = '0;
    addr = '0;
  endtask

  // Launch one slot with the current inputs on an idle DUT and wait it out.
  task automatic run_slot(input string name);
    exp_t e;
    int   k;
    predict(e, k);
    @(negedge clk) pix_start = 1'b1;
    @(negedge clk) pix_start = 1'b0;
    e.cyc = cyc + 1 + 2 * k;
    sb.push_back(e);
    repeat (2 + 2 * k) @(negedge clk);
    check({name, "_ready_back"}, 32'(ready), 32'd1);
    check({name, "_drained"}, sb.size(), 32'd0);
    check({name, "_pixel_hold"}, 32'(pixel_out), 32'(e.pixel));
  endtask

  task automatic set_slot(input int id);
    clear_inputs();
    case (id)
      0: begin req[0] = 1'b1; lay[0] = 2'd3; addr[0] = 16'h0010; end
      1: begin
        req[1] = 1'b1; lay[1] = 2'd1; addr[1] = 16'h0020;
        req[3] = 1'b1; lay[3] = 2'd0; addr[3] = 16'h0030;
      end
      2: ;
      3: begin
        req[4] = 1'b1; lay[4] = 2'd3; addr[4] = 16'h0011;
        req[5] = 1'b1; lay[5] = 2'd2; addr[5] = 16'h0021;
      end
      default: begin
        req = '1;
        for (int i = 0; i < NB; i++) begin lay[i] = 2'd3; addr[i] = 16'h0060; end
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   k;
    int   seq [4] = '{0, 1, 2, 3};

    for (int a = 0; a < 65536; a++) mem[a] = '0;
    reset     = 1'b1;
    pix_start = 1'b0;
    bg        = 12'h00F;
    key       = 12'h000;
    clear_inputs();
    repeat (3) @(negedge clk);

    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_add", 32'(rd_add), 32'd0);
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_coll_mask", 32'(collision_mask), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single opaque layer.
    mem[16'h0010] = 12'hABC;
    set_slot(0);
    rd_log.delete();
    run_slot("t1");
    check("t1_nreads", rd_log.size(), 32'd1);
    if (rd_log.size() > 0) check("t1_add0", 32'(rd_log[0]), 32'h10);

    // Top layer transparent, layer 2 skipped, layer 1 opaque.
    mem[16'h0010] = 12'h000;
    mem[16'h0020] = 12'h123;
    clear_inputs();
    req[0] = 1'b1; lay[0] = 2'd3; addr[0] = 16'h0010;
    req[1] = 1'b1; lay[1] = 2'd1; addr[1] = 16'h0020;
    rd_log.delete();
    run_slot("t2");
    check("t2_nreads", rd_log.size(), 32'd2);
    if (rd_log.size() == 2) begin
      check("t2_add0", 32'(rd_log[0]), 32'h10);
      check("t2_add1", 32'(rd_log[1]), 32'h20);
    end

    // No requests: background without any read.
    clear_inputs();
    rd_log.delete();
    run_slot("t3a");
    check("t3a_nreads", rd_log.size(), 32'd0);

    // All requested layers transparent.
    mem[16'h0030] = 12'h000;
    clear_inputs();
    req[0] = 1'b1; lay[0] = 2'd3; addr[0] = 16'h0010;
    req[1] = 1'b1; lay[1] = 2'd1; addr[1] = 16'h0030;
    rd_log.delete();
    run_slot("t3b");
    check("t3b_nreads", rd_log.size(), 32'd2);

    // Same-layer conflict; non-requesting blob on top layer is ignored.
    mem[16'h0040] = 12'h456;
    mem[16'h0050] = 12'h789;
    mem[16'h0060] = 12'h777;
    clear_inputs();
    req[2] = 1'b1; lay[2] = 2'd2; addr[2] = 16'h0040;
    req[5] = 1'b1; lay[5] = 2'd2; addr[5] = 16'h0050;
    req[6] = 1'b0; lay[6] = 2'd3; addr[6] = 16'h0060;
    rd_log.delete();
    run_slot("t4");
    check("t4_nreads", rd_log.size(), 32'd1);
    if (rd_log.size() > 0) check("t4_add0", 32'(rd_log[0]), 32'h40);
`ifdef LAYER_COMPOSITOR_COLLISION_EN
    check("t4_mask_const", 32'(collision_mask), 32'h24);
`else
    check("t4_mask_off", 32'(collision_mask), 32'h00);
`endif

    // pix_start held high; inputs scrambled mid-scan.
    mem[16'h0010] = 12'hABC;
    mem[16'h0011] = 12'h000;
    mem[16'h0021] = 12'h5A5;
    set_slot(seq[0]);
    @(negedge clk) pix_start = 1'b1;
    for (int s = 0; s < 4; s++) begin
      predict(e, k);
      @(negedge clk);
      e.cyc = cyc + 1 + 2 * k;
      sb.push_back(e);
      check("t5_busy", 32'(ready), 32'd0);
      if (s == 3) pix_start = 1'b0;
      set_slot(9);
      repeat (1 + 2 * k) @(negedge clk);
      if (s < 3) set_slot(seq[s + 1]);
      @(negedge clk);
      check("t5_idle", 32'(ready), 32'd1);
    end
    repeat (2) @(negedge clk);
    check("t5_drained", sb.size(), 32'd0);

    // Reset while in CHECK aborts the slot.
    mem[16'h0010] = 12'hABC;
    set_slot(0);
    @(negedge clk) pix_start = 1'b1;
    @(negedge clk) pix_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_rd_en", 32'(rd_en), 32'd0);
    check("t6_pixel_out", 32'(pixel_out), 32'd0);
    check("t6_no_valid", 32'(pixel_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("t6_drained", sb.size(), 32'd0);
    rd_log.delete();
    run_slot("t6_after");
    check("t6_nreads", rd_log.size(), 32'd1);

    check("final_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
